mul_seq_ctrl: RTL and testbench

Iterative shift-and-add controller for unsigned mantissa multiplication built around one shared 40-bit ripple adder. It accepts two WIDTH-bit operands over a valid/ready handshake and runs one add-and-shift iteration per clock. It returns the 2·WIDTH-bit product over a second valid/ready handshake. It sits between operand unpacking and product normalisation in the floating-point multiply path, and replaces a full array multiplier with a single reused adder.

---
 rtl/mul_seq_pkg.sv | 20 ++
 rtl/add_40bits.sv | 27 ++
 rtl/mul_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared sizing constants and FSM state type
// for the sequential shift-and-add mantissa multiplier.
package mul_seq_pkg;

    localparam int WIDTH_DEF = 20;
    localparam int ACC_W     = 40;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_40bits.sv
// add_40bits: plain 40-bit ripple-carry adder, one full adder
// per bit, carry chained from bit 0 upward.
module add_40bits
    import mul_seq_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             cin,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    logic [ACC_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < ACC_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[ACC_W];

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative unsigned multiplier, one add-and-shift per clock.
// Define MUL_SEQ_EARLY_EXIT_EN to leave CALC once the multiplier runs out of ones.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_data_a,
    input  logic [WIDTH-1:0]   i_data_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_data,
    output logic               o_busy
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (2 * WIDTH > ACC_W) begin : g_width_chk
        $error("mul_seq_ctrl: 2*WIDTH exceeds accumulator width");
    end

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mcand;
    logic [ACC_W-1:0] sum;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mplier_shr;
    logic [CW-1:0]    cnt;
    logic             last_iter;
    logic             carry_unused;

    add_40bits u_add (
        .a    (acc),
        .b    (mcand),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry_unused)
    );

    assign mplier_shr = mplier >> 1;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // no ones left to add: the accumulator already holds the product
    assign last_iter = (cnt == CNT_LAST) || (mplier_shr == '0);
`else
    assign last_iter = (cnt == CNT_LAST);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        o_data    = '0;
        unique case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                o_busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                o_data  = acc[2*WIDTH-1:0];
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (state == IDLE && i_valid) begin
            acc    <= '0;
            mcand  <= {{(ACC_W - WIDTH){1'b0}}, i_data_a};
            mplier <= i_data_b;
            cnt    <= '0;
        end else if (state == CALC) begin
            if (mplier[0]) begin
                acc <= sum;
            end
            mcand  <= mcand << 1;
            mplier <= mplier_shr;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: randomized self-checking bench for mul_seq_ctrl
// against an arithmetic reference (a*b, latency from multiplier bits).
module tb_mul_seq_ctrl;

    localparam int W = 20;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   i_data_a;
    logic [W-1:0]   i_data_b;
    logic           o_valid;
    logic           i_ready;
    logic [2*W-1:0] o_data;
    logic           o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    mul_seq_ctrl #(.WIDTH(W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_busy   (o_busy)
    );

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[2*W-1:0];
    endfunction

    function automatic int ref_latency(input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        int hi;
        hi = -1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) hi = i;
        end
        return (hi < 0) ? 1 : hi + 1;
`else
        return W + 0 * int'(b[0]);
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [2*W-1:0] prod);
        @(negedge i_clk);
        i_data_a = a;
        i_data_b = b;
        i_valid  = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 64) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        prod = o_data;
    endtask

    task automatic test_reset();
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_data_a = '0;
        i_data_b = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_ready); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
        n_checks++;
        if (o_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", o_data); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid_calc();
        bit seen;
        @(negedge i_clk);
        i_data_a = 20'hFFFFF;
        i_data_b = 20'hFFFFF;
        i_valid  = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy got %b want 1", o_busy); end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        n_checks++;
        if ({o_ready, o_busy, o_valid} !== 3'b100)
            begin n_fail++; $display("FAIL midrst_idle got rdy/busy/vld=%b want 100", {o_ready, o_busy, o_valid}); end
        i_ready = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_novalid got pulse=%b want 0", seen); end
    endtask

    task automatic test_vectors();
        logic [W-1:0]   va [5];
        logic [W-1:0]   vb [5];
        int             lat;
        logic [2*W-1:0] prod;
        va = '{20'hFFFFF, 20'h12345, 20'hABCDE, 20'h00000, 20'hFFFFF};
        vb = '{20'hFFFFF, 20'h00001, 20'h00000, 20'h80000, 20'h00003};
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_op(va[k], vb[k], lat, prod);
            n_checks++;
            if (prod !== ref_product(va[k], vb[k]))
                begin n_fail++; $display("FAIL vec%0d_data got %h want %h", k, prod, ref_product(va[k], vb[k])); end
            n_checks++;
            if (lat !== ref_latency(vb[k]))
                begin n_fail++; $display("FAIL vec%0d_latency got %0d want %0d", k, lat, ref_latency(vb[k])); end
            @(posedge i_clk);
            #1;
            n_checks++;
            if ({o_ready, o_valid} !== 2'b10)
                begin n_fail++; $display("FAIL vec%0d_handoff got rdy/vld=%b want 10", k, {o_ready, o_valid}); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
        int             lat;
        a   = W'($urandom);
        b   = W'($urandom) | 20'h80000;
        exp = ref_product(a, b);
        i_ready = 1'b0;
        @(negedge i_clk);
        i_data_a = a;
        i_data_b = b;
        i_valid  = 1'b1;
        @(posedge i_clk);
        #1;
        lat = 0;
        while (!o_valid && lat < 64) begin
            i_valid  = 1'($urandom);
            i_data_a = W'($urandom);
            i_data_b = W'($urandom);
            @(posedge i_clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== ref_latency(b)) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, ref_latency(b)); end
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk);
            #1;
            n_checks++;
            if ({o_valid, o_ready} !== 2'b10 || o_data !== exp)
                begin n_fail++; $display("FAIL bp_hold%0d got vld/rdy=%b data=%h want 10 %h", c, {o_valid, o_ready}, o_data, exp); end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        n_checks++;
        if ({o_ready, o_valid, o_busy} !== 3'b100)
            begin n_fail++; $display("FAIL bp_release got rdy/vld/busy=%b want 100", {o_ready, o_valid, o_busy}); end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] q [$];
        logic [2*W-1:0] exp;
        int             sent;
        int             rcv;
        int             gap;
        int             cyc;
        bit             acc_pend;
        bit             overlap;
        sent = 0; rcv = 0; gap = 0; cyc = 0;
        acc_pend = 1'b0;
        overlap  = 1'b0;
        i_valid  = 1'b0;
        while (rcv < 1000 && cyc < 60000) begin
            @(negedge i_clk);
            cyc++;
            if (acc_pend) begin
                i_valid  = 1'b0;
                gap      = $urandom_range(0, 2);
                acc_pend = 1'b0;
            end
            if (!i_valid && sent < 1000) begin
                if (gap == 0) begin
                    i_data_a = W'($urandom);
                    i_data_b = W'($urandom);
                    i_valid  = 1'b1;
                end else begin
                    gap--;
                end
            end
            i_ready = ($urandom_range(0, 3) != 0);
            if (o_valid && o_ready) overlap = 1'b1;
            if (o_valid && i_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra got %h want none", o_data);
                end else begin
                    exp = q.pop_front();
                    if (o_data !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_prod%0d got %h want %h", rcv, o_data, exp);
                    end
                end
                rcv++;
            end
            if (o_ready && i_valid) begin
                q.push_back(ref_product(i_data_a, i_data_b));
                sent++;
                acc_pend = 1'b1;
            end
        end
        i_valid = 1'b0;
        n_checks++;
        if (rcv !== 1000 || sent !== 1000 || q.size() != 0)
            begin n_fail++; $display("FAIL b2b_count got sent=%0d rcv=%0d left=%0d want 1000 1000 0", sent, rcv, q.size()); end
        n_checks++;
        if (overlap !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap got %b want 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_calc();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
